bcd_stopwatch: RTL and testbench
================================

// Module: bcd_stopwatch
// PURPOSE
//  Four-digit BCD stopwatch (SS.hh, 00.00-99.99 s) driving four hex 7-segment decoders on the board.
//  Sits directly upstream of the per-digit hex decoders: each digit output is a 4-bit code 0-9,
//  or 4'd10 ("E") on every digit after overflow. One button toggles run/stop; a second clears.
// PARAMETERS
//  CLK_FREQ_HZ  50_000_000  board clock frequency
//  TICK_HZ      100         count rate; one hundredths increment per tick
//  (derived) DIV = CLK_FREQ_HZ/TICK_HZ; must be >= 2; integer division, remainder ignored
// PORTS
//  clk        in   1  system clock, all logic on rising edge
//  rst        in   1  asynchronous, active-high reset
//  start_stop in   1  raw button level, asynchronous to clk; active-high
//  clear      in   1  synchronous, active-high clear (already debounced/synchronised)
//  dig0       out  4  hundredths of a second, 0-9 or 10
//  dig1       out  4  tenths, 0-9 or 10
//  dig2       out  4  seconds units, 0-9 or 10
//  dig3       out  4  seconds tens, 0-9 or 10
//  running    out  1  1 while counting
//  overflow   out  1  sticky; 1 after 99.99 rolled over
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-count): dig0..dig3=0, running=0, overflow=0, prescaler=0,
//    sync flops=0. Outputs are registered; no combinational path from inputs to outputs.
//  - start_stop: 2-flop synchroniser, then edge register; rise = sync2 & ~prev.
//    running toggles on the clock edge after rise is seen: 3 clk edges after input goes high.
//    Holding the button produces exactly one toggle. No debounce here (upstream's job).
//  - Prescaler: counts 0..DIV-1 only while running; tick=1 for one cycle when cnt==DIV-1, then cnt->0.
//    Stopping freezes cnt (resume continues the partial period); first tick DIV cycles after run.
//  - On tick: dig0+1; digit at 9 wraps to 0 and carries into the next. All four digits update in the
//    same cycle (no ripple latency).
//  - Overflow: tick while 99.99 -> overflow=1, running=0, dig0..dig3=4'd10 same edge.
//    While overflow=1: start_stop rises ignored, digits hold 10, prescaler held at 0.
//  - clear (sync): digits=0, prescaler=0, running=0, overflow=0 next edge.
//    Priority: clear > tick > start_stop toggle. rise and tick same cycle: tick applied AND running
//    toggles (count includes that tick). clear during overflow exits overflow.
//  - Digits never hold 11-15.
// STRUCTURE
//  - Shared package: CODE_E = 4'd10, BCD_MAX = 4'd9, NUM_DIGITS = 4; also consumed by the hex decoder.
//  - Submodule bcd_digit_cnt (x4): inputs clk, rst, clr, inc; outputs q[3:0], carry (inc & q==9).
//    Chained: inc(n+1) = carry(n). Overflow = carry out of dig3 on a tick; the top level forces CODE_E.
//  - Top level: synchroniser/edge detect, prescaler, run/overflow control.
// TESTING (sim with CLK_FREQ_HZ=400, TICK_HZ=100 -> DIV=4)
//  1 rst high mid-sim with digits=12.34, running=1 -> all outputs 0 immediately (before next clk).
//  2 start_stop high 10 clk -> running=1 exactly 3 edges after rise, single toggle; 40 clk later dig1=1,
//    dig0=0.
//  3 preload to 09.99 via counting; next tick -> dig3..dig0 = 1,0,0,0 in one cycle.
//  4 count to 99.99, one more tick -> overflow=1, running=0, all digits=10; start_stop pulse ignored;
//    clear -> 00.00, overflow=0.
//  5 stop after 2 prescaler cycles, idle 20 clk, restart -> next tick 2 clk after running=1
//    (partial period kept).
//  6 clear and start_stop rise in the same cycle while running -> digits 0, running=0.

Source files
------------

// File: rtl/bcd_stopwatch_pkg.sv
// Shared constants for the BCD stopwatch and the downstream hex decoders.
// Also holds the single-digit BCD increment helper used by the digit counters.
package bcd_stopwatch_pkg;

  localparam logic [3:0] CODE_E     = 4'd10;
  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam int         NUM_DIGITS = 4;

  function automatic logic [3:0] bcd_inc(input logic [3:0] q);
    logic [3:0] nxt;
    if (q >= BCD_MAX) begin
      nxt = 4'd0;
    end else begin
      nxt = q + 4'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bcd_stopwatch_digit.sv
// One BCD decade counter. carry is combinational so a whole chain of
// digits advances on the same clock edge.
module bcd_digit_cnt
  import bcd_stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry
);

  logic [3:0] q_r;

  // Decade state; an illegal code (11-15) self-recovers to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= 4'd0;
    end else if (clr) begin
      q_r <= 4'd0;
    end else if (q_r > BCD_MAX) begin
      q_r <= 4'd0;
    end else if (inc) begin
      q_r <= bcd_inc(q_r);
    end else begin
      q_r <= q_r;
    end
  end

  assign q     = q_r;
  assign carry = inc & (q_r == BCD_MAX);

endmodule

// File: rtl/bcd_stopwatch.sv
// Four-digit SS.hh stopwatch: button synchroniser, tick prescaler,
// run/overflow control and a chain of BCD decade counters.
module bcd_stopwatch
  import bcd_stopwatch_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int TICK_HZ     = 100
)
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       clear,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3,
  output logic       running,
  output logic       overflow
);

  localparam int             DIV      = CLK_FREQ_HZ / TICK_HZ;
  localparam int             CW       = $clog2(DIV);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DIV - 1);

  logic                sync1_r;
  logic                sync2_r;
  logic                prev_r;
  logic                rise_s;
  logic [CW-1:0]       cnt_r;
  logic                tick_s;
  logic                running_r;
  logic                overflow_r;
  logic [NUM_DIGITS:0] inc_s;
  logic [3:0]          q_s [NUM_DIGITS];

  // Two-flop synchroniser plus previous-level register for rise detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
    end else begin
      sync1_r <= start_stop;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  assign rise_s = sync2_r & ~prev_r;
  assign tick_s = running_r & (cnt_r == CNT_LAST);

  // Prescaler freezes while stopped so a restart resumes the partial period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clear || overflow_r) begin
      cnt_r <= '0;
    end else if (running_r) begin
      cnt_r <= (cnt_r == CNT_LAST) ? '0 : cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign inc_s[0] = tick_s;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    bcd_digit_cnt u_dig (
      .clk   (clk),
      .rst   (rst),
      .clr   (clear),
      .inc   (inc_s[i]),
      .q     (q_s[i]),
      .carry (inc_s[i+1])
    );
  end

  // Run/overflow control: clear beats the overflowing tick, which beats a toggle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running_r  <= 1'b0;
      overflow_r <= 1'b0;
    end else if (clear) begin
      running_r  <= 1'b0;
      overflow_r <= 1'b0;
    end else if (inc_s[NUM_DIGITS]) begin
      running_r  <= 1'b0;
      overflow_r <= 1'b1;
    end else if (rise_s && !overflow_r) begin
      running_r  <= ~running_r;
      overflow_r <= overflow_r;
    end else begin
      running_r  <= running_r;
      overflow_r <= overflow_r;
    end
  end

  // Outputs depend only on flops; after overflow every digit shows "E".
  assign dig0     = overflow_r ? CODE_E : q_s[0];
  assign dig1     = overflow_r ? CODE_E : q_s[1];
  assign dig2     = overflow_r ? CODE_E : q_s[2];
  assign dig3     = overflow_r ? CODE_E : q_s[3];
  assign running  = running_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Bench for bcd_stopwatch at DIV=4: elapsed time is modelled as an integer
// count of hundredths and compared against the DUT every cycle.
module tb_bcd_stopwatch;

  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_stop = 1'b0;
  logic clear = 1'b0;
  logic [3:0] dig0, dig1, dig2, dig3;
  logic running, overflow;
  logic [17:0] dut_vec;

  int n_checks = 0;
  int n_pass   = 0;

  bit m_s1, m_s2, m_prev, m_run, m_ovf;
  int m_count, m_ph;

  bcd_stopwatch #(.CLK_FREQ_HZ(400), .TICK_HZ(100)) dut (
    .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear),
    .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
    .running(running), .overflow(overflow)
  );

  always #5 clk = ~clk;

  assign dut_vec = {overflow, running, dig3, dig2, dig1, dig0};

  function automatic logic [17:0] model_vec(input int c, input bit o, input bit r);
    logic [15:0] d;
    if (o) d = 16'hAAAA;
    else   d = {4'((c / 1000) % 10), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
    return {o, r, d};
  endfunction

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_prev = 0; m_run = 0; m_ovf = 0; m_count = 0; m_ph = 0;
  endtask

  // One clock edge of the stopwatch's specified behaviour.
  task automatic model_edge(input bit ss, input bit clr);
    bit rise, tick, wrap;
    rise = m_s2 && !m_prev;
    tick = m_run && (m_ph == DIV - 1);
    wrap = tick && (m_count == 9999);
    if (clr) begin
      m_count = 0; m_ph = 0; m_run = 0; m_ovf = 0;
    end else begin
      if (m_ovf) m_ph = 0;
      else if (m_run) m_ph = (m_ph + 1) % DIV;
      if (wrap) begin
        m_ovf = 1; m_run = 0; m_count = 0;
      end else begin
        if (tick) m_count = m_count + 1;
        if (rise && !m_ovf) m_run = !m_run;
      end
    end
    m_prev = m_s2; m_s2 = m_s1; m_s1 = ss;
  endtask

  task automatic step(input bit ss, input bit clr);
    start_stop = ss;
    clear = clr;
    @(posedge clk);
    model_edge(ss, clr);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    n_checks++;
    if (dut_vec !== 18'd0) $display("FAIL reset_state got %h exp %h", dut_vec, 18'd0);
    else n_pass++;
  endtask

  task automatic test_start();
    for (int i = 1; i <= 43; i++) begin
      step((i <= 10), 1'b0);
      n_checks++;
      if (dut_vec !== model_vec(m_count, m_ovf, m_run))
        $display("FAIL start cyc%0d got %h exp %h", i, dut_vec, model_vec(m_count, m_ovf, m_run));
      else n_pass++;
      if (i == 2 || i == 3) begin
        n_checks++;
        if (running !== (i == 3)) $display("FAIL start_latency edge%0d got %b exp %b", i, running, (i == 3));
        else n_pass++;
      end
    end
    n_checks++;
    if ({running, dig1, dig0} !== {1'b1, 4'd1, 4'd0})
      $display("FAIL start_40clk got run=%b %0d%0d exp run=1 10", running, dig1, dig0);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    int guard = 0;
    while (m_count != 1234 && guard < 6000) begin
      step(1'b0, 1'b0);
      guard++;
    end
    n_checks++;
    if ({running, dig3, dig2, dig1, dig0} !== {1'b1, 16'h1234})
      $display("FAIL preload_1234 got %h exp %h", {running, dig3, dig2, dig1, dig0}, {1'b1, 16'h1234});
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (dut_vec !== 18'd0) $display("FAIL async_reset got %h exp %h", dut_vec, 18'd0);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_carry();
    int guard = 0;
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
    while (!(m_count == 999 && m_ph == DIV - 1) && guard < 5000) begin
      step(1'b0, 1'b0);
      guard++;
      n_checks++;
      if (dut_vec !== model_vec(m_count, m_ovf, m_run))
        $display("FAIL carry_run got %h exp %h", dut_vec, model_vec(m_count, m_ovf, m_run));
      else n_pass++;
    end
    n_checks++;
    if ({dig3, dig2, dig1, dig0} !== 16'h0999) $display("FAIL carry_pre got %h exp 0999", {dig3, dig2, dig1, dig0});
    else n_pass++;
    step(1'b0, 1'b0);
    n_checks++;
    if ({dig3, dig2, dig1, dig0} !== 16'h1000) $display("FAIL carry_ripple got %h exp 1000", {dig3, dig2, dig1, dig0});
    else n_pass++;
  endtask

  task automatic test_overflow();
    int guard = 0;
    while (!(m_count == 9999 && m_ph == DIV - 1) && guard < 40000) begin
      step(1'b0, 1'b0);
      guard++;
      n_checks++;
      if (dut_vec !== model_vec(m_count, m_ovf, m_run))
        $display("FAIL ovf_run got %h exp %h", dut_vec, model_vec(m_count, m_ovf, m_run));
      else n_pass++;
    end
    step(1'b0, 1'b0);
    n_checks++;
    if (dut_vec !== {1'b1, 1'b0, 16'hAAAA}) $display("FAIL overflow_set got %h exp %h", dut_vec, {1'b1, 1'b0, 16'hAAAA});
    else n_pass++;
    for (int i = 0; i < 10; i++) step((i < 5), 1'b0);
    n_checks++;
    if (dut_vec !== {1'b1, 1'b0, 16'hAAAA}) $display("FAIL overflow_hold got %h exp %h", dut_vec, {1'b1, 1'b0, 16'hAAAA});
    else n_pass++;
    step(1'b0, 1'b1);
    n_checks++;
    if (dut_vec !== 18'd0) $display("FAIL overflow_clear got %h exp %h", dut_vec, 18'd0);
    else n_pass++;
  endtask

  task automatic test_partial();
    int cyc = 0;
    int guard = 0;
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0);
    n_checks++;
    if (running !== 1'b1) $display("FAIL partial_start got %b exp 1", running);
    else n_pass++;
    step(1'b1, 1'b0); step(1'b1, 1'b0);
    n_checks++;
    if (running !== 1'b0) $display("FAIL partial_stop got %b exp 0", running);
    else n_pass++;
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
    n_checks++;
    if (dut_vec !== model_vec(m_count, m_ovf, m_run)) $display("FAIL partial_idle got %h exp %h", dut_vec, model_vec(m_count, m_ovf, m_run));
    else n_pass++;
    while (running !== 1'b1 && guard < 10) begin step(1'b1, 1'b0); guard++; end
    while (dig0 === 4'd0 && cyc < 10) begin step(1'b1, 1'b0); cyc++; end
    n_checks++;
    if (cyc !== 2) $display("FAIL partial_resume got %0d clk exp 2 clk", cyc);
    else n_pass++;
  endtask

  task automatic test_clear_rise();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b1);
    n_checks++;
    if (dut_vec !== 18'd0) $display("FAIL clear_vs_rise got %h exp %h", dut_vec, 18'd0);
    else n_pass++;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    n_checks++;
    if (running !== 1'b0) $display("FAIL clear_vs_rise_hold got %b exp 0", running);
    else n_pass++;
  endtask

  task automatic test_random();
    bit ss = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0) ss = !ss;
      step(ss, ($urandom_range(63) == 0));
      n_checks++;
      if (dut_vec !== model_vec(m_count, m_ovf, m_run))
        $display("FAIL random cyc%0d got %h exp %h", i, dut_vec, model_vec(m_count, m_ovf, m_run));
      else n_pass++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_start();
    test_async_reset();
    test_carry();
    test_overflow();
    test_partial();
    test_clear_rise();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
